// File: rtl/line_fill_server.sv
// Two-channel (instruction/data) cache line fill server over a single-port line memory.
// One transaction at a time: IDLE -> WAIT (LATENCY cycles) -> RESP (one-cycle valid pulse).
module line_fill_server #(
    parameter int WORDS    = 4,
    parameter int DEPTH    = 256,
    parameter int LATENCY  = 4,
    parameter int ARB_MODE = 0,
    parameter int COUNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_valid,
    output logic [32*WORDS-1:0]   i_line,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_valid,
    output logic [32*WORDS-1:0]   d_line,
    output logic                  busy,
    output logic [COUNT_W-1:0]    i_count,
    output logic [COUNT_W-1:0]    d_count
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LINE_W = 32 * WORDS;
    localparam int WC_W   = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic [WC_W-1:0]     wait_cnt_reg;
    logic                grant_d_reg;
    logic                last_d_reg;
    logic                we_reg;
    logic [OFF_W-1:0]    off_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [31:0]         wdata_reg;
    logic [LINE_W-1:0]   i_line_reg, d_line_reg;
    logic [COUNT_W-1:0]  i_count_reg, d_count_reg;

    logic [LINE_W-1:0]   mem [DEPTH];
    logic [LINE_W-1:0]   rd_line_reg;
    logic [LINE_W-1:0]   merged_line;

    logic                any_req, grant_d, wait_done;
    logic [OFF_W-1:0]    sel_off;
    logic [IDX_W-1:0]    sel_idx, rd_idx;
    logic                addr_unused;

    assign any_req   = i_req | d_req;
    // Round-robin: on a tie, D wins only if I was granted last.
    assign grant_d   = (ARB_MODE == 0) ? d_req : (d_req & (~i_req | ~last_d_reg));
    assign sel_off   = grant_d ? d_addr[2 +: OFF_W] : i_addr[2 +: OFF_W];
    assign sel_idx   = grant_d ? d_addr[2+OFF_W +: IDX_W] : i_addr[2+OFF_W +: IDX_W];
    assign wait_done = (wait_cnt_reg == WC_W'(LATENCY - 1));
    assign addr_unused = ^{i_addr, d_addr};

    // Read is issued on the grant edge so the line is ready from the first WAIT cycle.
    assign rd_idx = (state_reg == IDLE) ? sel_idx : idx_reg;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_merge
            assign merged_line[32*gi +: 32] = (we_reg && off_reg == OFF_W'(gi))
                                            ? wdata_reg : rd_line_reg[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req)   state_next = WAIT;
            WAIT:    if (wait_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory is never reset; a reset on the WAIT->RESP edge suppresses the write.
    always_ff @(posedge clk) begin
        rd_line_reg <= mem[rd_idx];
        if (!rstn && state_reg == WAIT && wait_done && we_reg)
            mem[idx_reg] <= merged_line;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            grant_d_reg  <= 1'b0;
            last_d_reg   <= 1'b1;
            we_reg       <= 1'b0;
            off_reg      <= '0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            i_line_reg   <= '0;
            d_line_reg   <= '0;
            i_count_reg  <= '0;
            d_count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_d_reg  <= grant_d;
                        last_d_reg   <= grant_d;
                        we_reg       <= grant_d & d_we;
                        off_reg      <= sel_off;
                        idx_reg      <= sel_idx;
                        wdata_reg    <= d_wdata;
                        wait_cnt_reg <= '0;
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (wait_done) begin
                        if (grant_d_reg) d_line_reg <= merged_line;
                        else             i_line_reg <= merged_line;
                    end
                end
                RESP: begin
                    if (grant_d_reg) begin
                        if (d_count_reg != '1) d_count_reg <= d_count_reg + 1'b1;
                    end else begin
                        if (i_count_reg != '1) i_count_reg <= i_count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_valid = (state_reg == RESP) && !grant_d_reg;
    assign d_valid = (state_reg == RESP) &&  grant_d_reg;
    assign busy    = (state_reg != IDLE);
    assign i_line  = i_line_reg;
    assign d_line  = d_line_reg;
    assign i_count = i_count_reg;
    assign d_count = d_count_reg;
endmodule

// File: tb/tb_line_fill_server.sv
// Bench for line_fill_server: two instances (fixed priority / 16-bit counters and
// round-robin / 2-bit counters) checked every cycle against a transaction-level model.
module tb_line_fill_server;
    localparam int WORDS = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int NW    = WORDS * DEPTH;

    logic clk = 1'b0;
    logic srst;
    logic i_req_v [2];
    logic d_req_v [2];
    logic [31:0] i_addr, d_addr, d_wdata;
    logic d_we;

    logic iv [2];
    logic dv [2];
    logic bz [2];
    logic [32*WORDS-1:0] il [2];
    logic [32*WORDS-1:0] dl [2];
    logic [15:0] ic0, dc0;
    logic [1:0]  ic1, dc1;

    always #5 clk = ~clk;

    line_fill_server #(.WORDS(WORDS), .DEPTH(DEPTH), .LATENCY(LAT), .ARB_MODE(0), .COUNT_W(16)) u0 (
        .clk(clk), .rstn(srst),
        .i_req(i_req_v[0]), .i_addr(i_addr), .i_valid(iv[0]), .i_line(il[0]),
        .d_req(d_req_v[0]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(dv[0]), .d_line(dl[0]), .busy(bz[0]), .i_count(ic0), .d_count(dc0));

    line_fill_server #(.WORDS(WORDS), .DEPTH(DEPTH), .LATENCY(LAT), .ARB_MODE(1), .COUNT_W(2)) u1 (
        .clk(clk), .rstn(srst),
        .i_req(i_req_v[1]), .i_addr(i_addr), .i_valid(iv[1]), .i_line(il[1]),
        .d_req(d_req_v[1]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(dv[1]), .d_line(dl[1]), .busy(bz[1]), .i_count(ic1), .d_count(dc1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int cyc = 0;
    bit act [2];
    int resp_c [2];
    bit gd [2];
    bit we_c [2];
    int idx_c [2];
    int off_c [2];
    logic [31:0] wd_c [2];
    bit last_d [2];
    int icnt [2];
    int dcnt [2];
    logic [31:0] mem_m [2][NW];
    bit known [2][NW];
    logic [31:0] iline [2][WORDS];
    logic [31:0] dline [2][WORDS];
    bit iknown [2][WORDS];
    bit dknown [2][WORDS];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int cmax;
            cmax = (k == 0) ? 65535 : 3;
            if (srst) begin
                act[k] = 0;
                last_d[k] = 1;
                icnt[k] = 0;
                dcnt[k] = 0;
                for (int w = 0; w < WORDS; w++) begin
                    iline[k][w] = 0; dline[k][w] = 0;
                    iknown[k][w] = 1; dknown[k][w] = 1;
                end
            end else if (act[k] && cyc == resp_c[k] - 1) begin
                int base;
                base = idx_c[k] * WORDS;
                if (we_c[k]) begin
                    mem_m[k][base + off_c[k]] = wd_c[k];
                    known[k][base + off_c[k]] = 1;
                end
                for (int w = 0; w < WORDS; w++) begin
                    if (gd[k]) begin
                        dline[k][w] = mem_m[k][base + w]; dknown[k][w] = known[k][base + w];
                    end else begin
                        iline[k][w] = mem_m[k][base + w]; iknown[k][w] = known[k][base + w];
                    end
                end
            end else if (act[k] && cyc == resp_c[k]) begin
                if (gd[k]) dcnt[k] = (dcnt[k] < cmax) ? dcnt[k] + 1 : cmax;
                else       icnt[k] = (icnt[k] < cmax) ? icnt[k] + 1 : cmax;
                act[k] = 0;
            end else if (!act[k] && (i_req_v[k] || d_req_v[k])) begin
                int unsigned a;
                if (k == 0) gd[k] = d_req_v[k];
                else        gd[k] = d_req_v[k] && (!i_req_v[k] || !last_d[k]);
                last_d[k] = gd[k];
                a = gd[k] ? d_addr : i_addr;
                off_c[k] = (a / 4) % WORDS;
                idx_c[k] = (a / (4 * WORDS)) % DEPTH;
                we_c[k] = gd[k] && d_we;
                wd_c[k] = d_wdata;
                resp_c[k] = cyc + LAT + 1;
                act[k] = 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit rv;
            rv = act[k] && (cyc == resp_c[k]);
            chk("busy", k, 32'(bz[k]), 32'(act[k]));
            chk("i_valid", k, 32'(iv[k]), 32'(rv && !gd[k]));
            chk("d_valid", k, 32'(dv[k]), 32'(rv && gd[k]));
            chk("i_count", k, (k == 0) ? 32'(ic0) : 32'(ic1), icnt[k]);
            chk("d_count", k, (k == 0) ? 32'(dc0) : 32'(dc1), dcnt[k]);
            for (int w = 0; w < WORDS; w++) begin
                if (iknown[k][w]) chk("i_line_word", k, il[k][32*w +: 32], iline[k][w]);
                if (dknown[k][w]) chk("d_line_word", k, dl[k][32*w +: 32], dline[k][w]);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while ((bz[0] || bz[1]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 0, 32'(bz[0] | bz[1]), 0);
    endtask

    task automatic d_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [32*WORDS-1:0] line0);
        wait_idle();
        i_req_v = '{1'b0, 1'b0};
        d_req_v = '{1'b1, 1'b1};
        d_we = we; d_addr = a; d_wdata = wd;
        @(negedge clk);
        d_req_v = '{1'b0, 1'b0};
        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        lat = 1;
        while (!dv[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        line0 = dl[0];
    endtask

    task automatic i_op(input logic [31:0] a, output int lat, output logic [32*WORDS-1:0] line0);
        wait_idle();
        d_req_v = '{1'b0, 1'b0};
        i_req_v = '{1'b1, 1'b1};
        i_addr = a;
        @(negedge clk);
        i_req_v = '{1'b0, 1'b0};
        i_addr = $urandom;
        lat = 1;
        while (!iv[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        line0 = il[0];
    endtask

    initial begin
        int lat;
        int ifirst [2];
        int dfirst [2];
        int seen;
        logic [32*WORDS-1:0] ln;
        logic [31:0] prog [4];

        srst = 1'b1;
        i_req_v = '{1'b0, 1'b0};
        d_req_v = '{1'b0, 1'b0};
        i_addr = 0; d_addr = 0; d_wdata = 0; d_we = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, 32'(bz[k]), 0);
            chk("rst_i_valid", k, 32'(iv[k]), 0);
            chk("rst_d_valid", k, 32'(dv[k]), 0);
            chk("rst_i_line_lo", k, il[k][31:0], 0);
            chk("rst_d_line_hi", k, dl[k][127:96], 0);
        end
        chk("rst_i_count", 0, 32'(ic0), 0);
        chk("rst_d_count", 1, 32'(dc1), 0);
        srst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 0, 32'(bz[0] | bz[1]), 0);
        end

        // Simultaneous requests: fixed priority serves D first, round-robin serves I first.
        ifirst = '{0, 0};
        dfirst = '{0, 0};
        i_addr = 32'h0; d_addr = 32'h0; d_we = 0;
        i_req_v = '{1'b1, 1'b1};
        d_req_v = '{1'b1, 1'b1};
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (iv[k] && ifirst[k] == 0) begin ifirst[k] = n; i_req_v[k] = 1'b0; end
                if (dv[k] && dfirst[k] == 0) begin dfirst[k] = n; d_req_v[k] = 1'b0; end
            end
        end
        i_req_v = '{1'b0, 1'b0};
        d_req_v = '{1'b0, 1'b0};
        chk("tie_fixed_d_lat", 0, dfirst[0], 5);
        chk("tie_fixed_i_lat", 0, ifirst[0], 11);
        chk("tie_rr_i_lat", 1, ifirst[1], 5);
        chk("tie_rr_d_lat", 1, dfirst[1], 11);

        // Write then read back through a different word offset of the same line.
        d_op(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, lat, ln);
        chk("wr_latency", 0, lat, 5);
        chk("wr_line_word2", 0, ln[95:64], 32'hDEAD_BEEF);
        d_op(1'b0, 32'h0000_0000, 32'h0, lat, ln);
        chk("rd_latency", 0, lat, 5);
        chk("rd_line_word2", 0, ln[95:64], 32'hDEAD_BEEF);

        // Instruction fetch of a line written by the data side, via a wrapping address.
        prog = '{32'h0043_0820, 32'h0000_0020, 32'h0000_0020, 32'h0021_0820};
        for (int w = 0; w < 4; w++) d_op(1'b1, 32'(4 * w), prog[w], lat, ln);
        i_op(32'h1000_0000, lat, ln);
        chk("fetch_latency", 0, lat, 5);
        chk("fetch_line_hi", 0, ln[127:96], 32'h0021_0820);
        chk("fetch_line_w2", 0, ln[95:64], 32'h0000_0020);
        chk("fetch_line_w1", 0, ln[63:32], 32'h0000_0020);
        chk("fetch_line_lo", 0, ln[31:0], 32'h0043_0820);

        // Reset two cycles after grant aborts the write.
        wait_idle();
        d_req_v = '{1'b1, 1'b1};
        d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h1234_5678;
        @(negedge clk);
        d_req_v = '{1'b0, 1'b0};
        d_we = 1'b0;
        @(negedge clk);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (dv[0] || dv[1]) seen++;
        end
        chk("abort_no_valid", 0, seen, 0);
        d_op(1'b0, 32'h4, 32'h0, lat, ln);
        chk("abort_prior_word", 0, ln[63:32], 32'h0000_0020);

        // Counter saturation on the 2-bit instance.
        wait_idle();
        srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        for (int r = 0; r < 5; r++) i_op($urandom, lat, ln);
        wait_idle();
        chk("sat_i_count", 1, 32'(ic1), 3);
        chk("sat_d_count", 1, 32'(dc1), 0);
        chk("full_i_count", 0, 32'(ic0), 5);
        chk("full_d_count", 0, 32'(dc0), 0);

        // Random traffic, independent per instance, over a few lines with wrapping high bits.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                i_req_v[k] = ($urandom % 3 == 0);
                d_req_v[k] = ($urandom % 3 == 0);
            end
            i_addr  = $urandom & 32'hF000_003C;
            d_addr  = $urandom & 32'hF000_003C;
            d_we    = 1'($urandom);
            d_wdata = $urandom;
            srst    = ($urandom % 150 == 0);
        end
        @(negedge clk);
        i_req_v = '{1'b0, 1'b0};
        d_req_v = '{1'b0, 1'b0};
        srst = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
